// File: rtl/i2c_poll_sequencer_pkg.sv
// Shared types for the I2C register poller: controller transaction kinds,
// poller FSM states and register-pointer arithmetic.
package i2c_poll_sequencer_pkg;

  typedef enum logic {
    WRITE_8BIT_REGISTER = 1'b0,
    READ_8BIT           = 1'b1
  } i2c_transaction_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PTR_REQ,
    S_PTR_WAIT,
    S_RD_REQ,
    S_RD_WAIT,
    S_COMMIT,
    S_ABORT
  } poll_state_t;

  // Register pointers wrap modulo 256 (base 8'hFF, offset 1 -> 8'h00).
  function automatic logic [7:0] reg_ptr(input logic [7:0] base, input logic [7:0] offset);
    return base + offset;
  endfunction

endpackage

// File: rtl/i2c_poll_sequencer_tick_gen.sv
// Free-running frame-rate divider: reloadable down-counter that emits a
// one-cycle tick each time it reaches zero.
module poll_tick_gen #(
  parameter int unsigned DIVIDE = 120_000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int unsigned CW = (DIVIDE > 1) ? $clog2(DIVIDE) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(DIVIDE - 1);

  logic [CW-1:0] cnt_q;
  logic          tick_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= RELOAD;
      tick_q <= 1'b0;
    end else if (cnt_q == '0) begin
      cnt_q  <= RELOAD;
      tick_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_q - 1'b1;
      tick_q <= 1'b0;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/i2c_poll_sequencer.sv
// Periodic I2C register poller: per frame writes each register pointer, reads
// one byte back, and publishes the whole set as one coherent snapshot.
module i2c_poll_sequencer
  import i2c_poll_sequencer_pkg::*;
#(
  parameter int unsigned CLK_HZ         = 12_000_000,
  parameter int unsigned POLL_HZ        = 100,
  parameter logic [6:0]  DEVICE_ADDR    = 7'h38,
  parameter logic [7:0]  BASE_REG       = 8'h03,
  parameter int unsigned NUM_REGS       = 4,
  parameter int unsigned TIMEOUT_CYCLES = 4000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ena,
  input  logic                    c_ready,
  output logic                    c_valid,
  output i2c_transaction_t        c_mode,
  output logic [6:0]              c_addr,
  output logic [7:0]              c_data,
  input  logic                    c_o_valid,
  input  logic [7:0]              c_o_data,
  output logic [NUM_REGS*8-1:0]   regs,
  output logic                    frame_valid,
  output logic                    busy,
  output logic                    timeout_err,
  output logic                    overrun_err
);

  localparam int unsigned DIVIDE = ((CLK_HZ / POLL_HZ) > 0) ? (CLK_HZ / POLL_HZ) : 1;
  localparam int unsigned IW     = $clog2(NUM_REGS) + 1;
  localparam int unsigned WW     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_REGS - 1);
  localparam logic [WW-1:0] WD_LOAD  = WW'(TIMEOUT_CYCLES - 1);

  logic tick;

  poll_tick_gen #(
    .DIVIDE (DIVIDE)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  poll_state_t           state_q;
  logic [IW-1:0]         idx_q;
  logic [WW-1:0]         wd_q;
  logic                  c_valid_q;
  i2c_transaction_t      c_mode_q;
  logic [7:0]            c_data_q;
  logic [NUM_REGS*8-1:0] shadow_q;
  logic [NUM_REGS*8-1:0] regs_q;
  logic                  frame_valid_q;
  logic                  timeout_err_q;
  logic                  overrun_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      idx_q         <= '0;
      wd_q          <= '0;
      c_valid_q     <= 1'b0;
      c_mode_q      <= WRITE_8BIT_REGISTER;
      c_data_q      <= '0;
      shadow_q      <= '0;
      regs_q        <= '0;
      frame_valid_q <= 1'b0;
      timeout_err_q <= 1'b0;
      overrun_err_q <= 1'b0;
    end else begin
      frame_valid_q <= 1'b0;
      if (tick && (state_q != S_IDLE)) begin
        overrun_err_q <= 1'b1;
      end

      // Watchdog is a down-counter loaded on every *_REQ entry; a completion
      // event in the same cycle as terminal count wins over the abort.
      case (state_q)
        S_IDLE: begin
          if (tick && ena) begin
            idx_q     <= '0;
            wd_q      <= WD_LOAD;
            c_valid_q <= 1'b1;
            c_mode_q  <= WRITE_8BIT_REGISTER;
            c_data_q  <= reg_ptr(BASE_REG, 8'd0);
            state_q   <= S_PTR_REQ;
          end
        end

        S_PTR_REQ: begin
          if (c_ready) begin
            c_valid_q <= 1'b0;
            wd_q      <= (wd_q == '0) ? '0 : wd_q - 1'b1;
            state_q   <= S_PTR_WAIT;
          end else if (wd_q == '0) begin
            c_valid_q <= 1'b0;
            state_q   <= S_ABORT;
          end else begin
            wd_q <= wd_q - 1'b1;
          end
        end

        S_PTR_WAIT: begin
          if (c_ready) begin
            wd_q      <= WD_LOAD;
            c_valid_q <= 1'b1;
            c_mode_q  <= READ_8BIT;
            state_q   <= S_RD_REQ;
          end else if (wd_q == '0) begin
            state_q <= S_ABORT;
          end else begin
            wd_q <= wd_q - 1'b1;
          end
        end

        S_RD_REQ: begin
          if (c_ready) begin
            c_valid_q <= 1'b0;
            wd_q      <= (wd_q == '0) ? '0 : wd_q - 1'b1;
            state_q   <= S_RD_WAIT;
          end else if (wd_q == '0) begin
            c_valid_q <= 1'b0;
            state_q   <= S_ABORT;
          end else begin
            wd_q <= wd_q - 1'b1;
          end
        end

        S_RD_WAIT: begin
          if (c_ready) begin
            if (!c_o_valid) begin
              state_q <= S_ABORT;
            end else begin
              for (int k = 0; k < NUM_REGS; k++) begin
                if (idx_q == IW'(k)) begin
                  shadow_q[8*k +: 8] <= c_o_data;
                end
              end
              if (idx_q == LAST_IDX) begin
                state_q <= S_COMMIT;
              end else begin
                idx_q     <= idx_q + 1'b1;
                wd_q      <= WD_LOAD;
                c_valid_q <= 1'b1;
                c_mode_q  <= WRITE_8BIT_REGISTER;
                c_data_q  <= reg_ptr(BASE_REG, 8'(idx_q + 1'b1));
                state_q   <= S_PTR_REQ;
              end
            end
          end else if (wd_q == '0) begin
            state_q <= S_ABORT;
          end else begin
            wd_q <= wd_q - 1'b1;
          end
        end

        S_COMMIT: begin
          regs_q        <= shadow_q;
          frame_valid_q <= 1'b1;
          state_q       <= S_IDLE;
        end

        S_ABORT: begin
          timeout_err_q <= 1'b1;
          state_q       <= S_IDLE;
        end

        default: begin
          c_valid_q <= 1'b0;
          state_q   <= S_IDLE;
        end
      endcase
    end
  end

  assign c_valid     = c_valid_q;
  assign c_mode      = c_mode_q;
  assign c_addr      = DEVICE_ADDR;
  assign c_data      = c_data_q;
  assign regs        = regs_q;
  assign frame_valid = frame_valid_q;
  assign busy        = (state_q != S_IDLE);
  assign timeout_err = timeout_err_q;
  assign overrun_err = overrun_err_q;

endmodule

// File: tb/tb_i2c_poll_sequencer.sv
// Bench for i2c_poll_sequencer: behavioural controller/target model answering
// reads with 8'hA0 + pointer + salt, plus a request/frame scoreboard.
module tb_i2c_poll_sequencer;
  import i2c_poll_sequencer_pkg::*;

  localparam int NREG = 4;
  localparam logic [7:0] PTR [NREG] = '{8'hFE, 8'hFF, 8'h00, 8'h01};

  logic             clk = 1'b0;
  logic             rst;
  logic             ena;
  logic             c_ready;
  logic             c_valid;
  i2c_transaction_t c_mode;
  logic [6:0]       c_addr;
  logic [7:0]       c_data;
  logic             c_o_valid;
  logic [7:0]       c_o_data;
  logic [31:0]      regs;
  logic             frame_valid;
  logic             busy;
  logic             timeout_err;
  logic             overrun_err;

  always #5 clk = ~clk;

  i2c_poll_sequencer #(
    .CLK_HZ         (1000),
    .POLL_HZ        (10),
    .DEVICE_ADDR    (7'h38),
    .BASE_REG       (8'hFE),
    .NUM_REGS       (NREG),
    .TIMEOUT_CYCLES (40)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ena         (ena),
    .c_ready     (c_ready),
    .c_valid     (c_valid),
    .c_mode      (c_mode),
    .c_addr      (c_addr),
    .c_data      (c_data),
    .c_o_valid   (c_o_valid),
    .c_o_data    (c_o_data),
    .regs        (regs),
    .frame_valid (frame_valid),
    .busy        (busy),
    .timeout_err (timeout_err),
    .overrun_err (overrun_err)
  );

  typedef struct packed {
    logic       mode;
    logic [7:0] data;
  } txn_t;

  txn_t        exp_txn[$];
  logic [31:0] exp_frame[$];
  int total = 0;
  int bad   = 0;
  int hs_cnt = 0;
  int fv_cnt = 0;
  int stall_samples = 0;

  int         lat = 2;
  int         stall_next = 0;
  bit         stuck = 1'b0;
  logic [7:0] salt = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  // Controller + target: c_ready drops the cycle after an accept, returns
  // after lat+1 cycles; reads come back with c_o_valid and the byte.
  initial begin : target_model
    bit         acc_pend = 1'b0;
    bit         rd = 1'b0;
    bit         stalling = 1'b0;
    int         cnt = 0;
    logic [7:0] ptr = 8'h00;
    c_ready   = 1'b1;
    c_o_valid = 1'b0;
    c_o_data  = 8'h00;
    forever begin
      @(negedge clk);
      if (acc_pend) begin
        acc_pend  = 1'b0;
        c_ready   = 1'b0;
        c_o_valid = 1'b0;
        cnt       = lat;
      end else if (!c_ready && !stuck) begin
        if (cnt > 0) cnt--;
        else begin
          c_ready = 1'b1;
          if (rd && !stalling) begin
            c_o_valid = 1'b1;
            c_o_data  = 8'hA0 + ptr + salt;
          end
          stalling = 1'b0;
        end
      end else if (c_ready && c_valid && stall_next > 0) begin
        c_ready    = 1'b0;
        cnt        = stall_next - 1;
        stall_next = 0;
        stalling   = 1'b1;
      end
      if (c_ready && c_valid) begin
        acc_pend = 1'b1;
        rd = (c_mode == READ_8BIT);
        if (!rd) ptr = c_data;
      end
    end
  end

  initial begin : monitor
    logic pv = 1'b0;
    logic pr = 1'b0;
    logic pm = 1'b0;
    logic pf = 1'b0;
    logic [7:0] pd = 8'h00;
    txn_t t;
    logic [31:0] ef;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        pv = 1'b0; pr = 1'b0; pf = 1'b0;
      end else begin
        if (pv && !pr) begin
          check("hold_valid", c_valid, 1);
          check("hold_data", c_data, pd);
          check("hold_mode", c_mode, pm);
        end
        if (pv && pr) check("drop_valid", c_valid, 0);
        if (c_valid && !c_ready) stall_samples++;
        if (c_valid && c_ready) begin
          hs_cnt++;
          if (exp_txn.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_txn: got mode=%0d data=%h want none", c_mode, c_data);
          end else begin
            t = exp_txn.pop_front();
            check("txn_mode", c_mode, t.mode);
            check("txn_data", c_data, t.data);
            check("txn_addr", c_addr, 7'h38);
          end
        end
        if (frame_valid) begin
          fv_cnt++;
          check("fv_single_cycle", pf, 0);
          if (exp_frame.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_frame: got regs=%h want none", regs);
          end else begin
            ef = exp_frame.pop_front();
            check("frame_regs", regs, ef);
          end
        end
        pv = c_valid; pr = c_ready; pd = c_data; pm = c_mode; pf = frame_valid;
      end
    end
  end

  task automatic push_frame(input logic [31:0] fr);
    txn_t t;
    for (int k = 0; k < NREG; k++) begin
      t.mode = 1'b0; t.data = PTR[k]; exp_txn.push_back(t);
      t.mode = 1'b1; t.data = PTR[k]; exp_txn.push_back(t);
    end
    exp_frame.push_back(fr);
  endtask

  task automatic wait_hs(input int target, input int budget, input string name);
    int n = 0;
    while (hs_cnt < target && n < budget) begin @(negedge clk); n++; end
    if (hs_cnt < target) begin
      total++; bad++;
      $display("FAIL %s_wait_txn: got %0d want %0d within %0d cycles", name, hs_cnt, target, budget);
    end
  endtask

  task automatic wait_fv(input int target, input int budget, input string name);
    int n = 0;
    while (fv_cnt < target && n < budget) begin @(negedge clk); n++; end
    if (fv_cnt < target) begin
      total++; bad++;
      $display("FAIL %s_wait_frame: got %0d want %0d within %0d cycles", name, fv_cnt, target, budget);
    end
  endtask

  task automatic run_frame(input string name, input logic [31:0] fr);
    int h0 = hs_cnt;
    int f0 = fv_cnt;
    push_frame(fr);
    ena = 1'b1;
    wait_hs(h0 + 1, 300, name);
    ena = 1'b0;
    wait_fv(f0 + 1, 1500, name);
    @(negedge clk);
    #1;
    check({name, "_busy"}, busy, 0);
    check({name, "_regs"}, regs, fr);
    check({name, "_txn_count"}, hs_cnt - h0, 8);
  endtask

  initial begin : global_guard
    #500_000;
    $display("FAIL global_timeout: got no end want finish");
    $fatal(1);
  end

  initial begin : stimulus
    int h0, f0, n;
    txn_t t;
    rst = 1'b1;
    ena = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_c_valid", c_valid, 0);
    check("rst_c_mode", c_mode, WRITE_8BIT_REGISTER);
    check("rst_c_data", c_data, 0);
    check("rst_regs", regs, 0);
    check("rst_busy", busy, 0);
    check("rst_errs", {timeout_err, overrun_err, frame_valid}, 0);
    check("rst_c_addr", c_addr, 7'h38);
    @(negedge clk);
    rst = 1'b0;

    // Basic frame with pointer wrap FE, FF, 00, 01.
    salt = 8'h00;
    run_frame("t1", 32'hA1A09F9E);

    // First request stalled four cycles by the controller.
    salt = 8'h04;
    stall_samples = 0;
    stall_next = 4;
    run_frame("t2", 32'hA5A4A3A2);
    check("t2_stall_cycles", stall_samples, 4);

    // Target stops answering after the first pointer write.
    stuck = 1'b1;
    h0 = hs_cnt; f0 = fv_cnt;
    t.mode = 1'b0; t.data = 8'hFE; exp_txn.push_back(t);
    ena = 1'b1;
    wait_hs(h0 + 1, 300, "t3");
    ena = 1'b0;
    n = 0;
    while (!timeout_err && n < 200) begin @(negedge clk); n++; end
    check("t3_timeout_err", timeout_err, 1);
    check("t3_timeout_latency_ok", (n >= 35 && n <= 45), 1);
    repeat (2) @(negedge clk);
    #1;
    check("t3_busy", busy, 0);
    check("t3_regs_kept", regs, 32'hA5A4A3A2);
    check("t3_no_frame", fv_cnt - f0, 0);
    stuck = 1'b0;
    repeat (10) @(negedge clk);
    salt = 8'h08;
    run_frame("t3r", 32'hA9A8A7A6);
    check("t3r_timeout_sticky", timeout_err, 1);
    check("t3r_no_overrun", overrun_err, 0);

    // Slow controller stretches the frame across several ticks.
    lat = 25;
    salt = 8'h20;
    run_frame("t4", 32'hC1C0BFBE);
    check("t4_overrun_err", overrun_err, 1);
    lat = 2;
    repeat (5) @(negedge clk);

    // ena dropped while reading register index 2.
    salt = 8'h30;
    h0 = hs_cnt; f0 = fv_cnt;
    push_frame(32'hD1D0CFCE);
    ena = 1'b1;
    wait_hs(h0 + 6, 600, "t5");
    ena = 1'b0;
    wait_fv(f0 + 1, 600, "t5");
    h0 = hs_cnt;
    repeat (300) @(negedge clk);
    #1;
    check("t5_no_new_txn", hs_cnt - h0, 0);
    check("t5_idle", busy, 0);
    check("t5_one_frame", fv_cnt - f0, 1);
    check("t5_regs", regs, 32'hD1D0CFCE);

    // Reset while waiting for the pointer write to finish.
    h0 = hs_cnt;
    t.mode = 1'b0; t.data = 8'hFE; exp_txn.push_back(t);
    ena = 1'b1;
    wait_hs(h0 + 1, 300, "t6");
    ena = 1'b0;
    @(negedge clk);
    #1;
    check("t6_busy_before_rst", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check("t6_busy", busy, 0);
    check("t6_c_valid", c_valid, 0);
    check("t6_regs", regs, 0);
    check("t6_errs", {timeout_err, overrun_err}, 0);
    check("t6_c_data", c_data, 0);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    salt = 8'h40;
    run_frame("t6r", 32'hE1E0DFDE);

    check("end_txn_queue", exp_txn.size(), 0);
    check("end_frame_queue", exp_frame.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
